// File: rtl/cacheline_burst_adaptor.sv
// cacheline_burst_adaptor: splits 256-bit cache line fills/write-backs into 64-bit memory bursts.
// Optional protocol checker enabled by CACHELINE_ADAPTOR_PROTOCOL_CHECK_EN.
module cacheline_burst_adaptor #(
    parameter int s_line  = 256,
    parameter int s_burst = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [s_line-1:0]  line_i,
    output logic [s_line-1:0]  line_o,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [s_burst-1:0] burst_i,
    output logic [s_burst-1:0] burst_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i,
    output logic               err_o
);
    localparam int beats = s_line / s_burst;
    localparam int bw = beats > 1 ? $clog2(beats) : 1;
    localparam int ob = $clog2(s_line / 8);
    localparam logic [bw-1:0] last = bw'(beats - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic [bw-1:0]     beat_q, beat_d;
    logic [31-ob:0]    addr_q, addr_d;
    logic [s_line-1:0] buf_q, buf_d, line_q, line_d;
    logic              read_q, write_q, resp_q;
    logic              unused_addr;

    assign unused_addr = ^address_i[ob-1:0];

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        buf_d   = buf_q;
        line_d  = line_q;
        case (state_q)
            IDLE: begin
                beat_d = '0;
                if (read_i) begin
                    state_d = READ;
                    addr_d  = address_i[31:ob];
                end else if (write_i) begin
                    state_d = WRITE;
                    addr_d  = address_i[31:ob];
                    buf_d   = line_i;
                end
            end
            READ: if (resp_i) begin
                line_d[beat_q*s_burst +: s_burst] = burst_i;
                beat_d  = beat_q + 1'b1;
                state_d = beat_q == last ? DONE : READ;
            end
            WRITE: if (resp_i) begin
                beat_d  = beat_q + 1'b1;
                state_d = beat_q == last ? DONE : WRITE;
            end
            default: begin
                state_d = IDLE;
                addr_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            addr_q  <= '0;
            buf_q   <= '0;
            line_q  <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
            line_q  <= line_d;
            read_q  <= state_d == READ;
            write_q <= state_d == WRITE;
            resp_q  <= state_d == DONE;
        end
    end

    assign line_o    = line_q;
    assign address_o = {addr_q, {ob{1'b0}}};
    assign read_o    = read_q;
    assign write_o   = write_q;
    assign resp_o    = resp_q;
    assign burst_o   = state_q == WRITE ? buf_q[beat_q*s_burst +: s_burst] : '0;

`ifdef CACHELINE_ADAPTOR_PROTOCOL_CHECK_EN
    logic [31:0] addr_prev_q;
    logic        err_q, err_d;

    // address_i is compared against its previous-cycle value, so any change mid-transfer is caught
    always_comb
        err_d = err_q
              | (state_q == IDLE && read_i && write_i)
              | ((state_q == IDLE || state_q == DONE) && resp_i)
              | ((state_q == READ || state_q == WRITE) && address_i != addr_prev_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q       <= 1'b0;
            addr_prev_q <= '0;
        end else begin
            err_q       <= err_d;
            addr_prev_q <= address_i;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// tb_cacheline_burst_adaptor: directed and randomized checks of the line/burst adaptor against a line-level model.
module tb_cacheline_burst_adaptor;
    logic         clk = 1'b0, rst = 1'b0;
    logic [255:0] line_i = '0, line_o;
    logic [31:0]  address_i = '0, address_o;
    logic         read_i = 1'b0, write_i = 1'b0, resp_o;
    logic [63:0]  burst_i = '0, burst_o;
    logic         read_o, write_o, resp_i = 1'b0, err_o;

`ifdef CACHELINE_ADAPTOR_PROTOCOL_CHECK_EN
    localparam bit chk_en = 1'b1;
`else
    localparam bit chk_en = 1'b0;
`endif

    int           n_chk = 0, n_fail = 0;
    logic [255:0] exp_line = '0;
    logic         exp_err = 1'b0;
    bit           resp_plan[$];
    logic [63:0]  beat_plan[$];

    always #5 clk = ~clk;

    cacheline_burst_adaptor dut (
        .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o),
        .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
        .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
        .read_o(read_o), .write_o(write_o), .resp_i(resp_i), .err_o(err_o)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic pick(input int sp, output bit r);
        if (resp_plan.size() > 0) r = resp_plan.pop_front();
        else r = $urandom_range(99) >= sp;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".read_o"}, 256'(read_o), 256'(1'b0));
        chk({tag, ".write_o"}, 256'(write_o), 256'(1'b0));
        chk({tag, ".resp_o"}, 256'(resp_o), 256'(1'b0));
        chk({tag, ".address_o"}, 256'(address_o), 256'(0));
        chk({tag, ".burst_o"}, 256'(burst_o), 256'(0));
        chk({tag, ".line_o"}, line_o, exp_line);
        chk({tag, ".err_o"}, 256'(err_o), 256'(exp_err));
    endtask

    task automatic do_read(input logic [31:0] a, input bit both, input int sp);
        logic [63:0] beats[4];
        logic [31:0] ea;
        int k;
        bit r;
        ea = {a[31:5], 5'b0};
        for (int i = 0; i < 4; i++) beats[i] = beat_plan.size() > 0 ? beat_plan.pop_front() : {$urandom, $urandom};
        address_i = a;
        read_i = 1'b1;
        write_i = both;
        line_i = {8{$urandom}};
        if (both) exp_err = exp_err | chk_en;
        next();
        read_i = 1'b0;
        write_i = 1'b0;
        k = 0;
        while (k < 4) begin
            chk("rd.read_o", 256'(read_o), 256'(1'b1));
            chk("rd.write_o", 256'(write_o), 256'(1'b0));
            chk("rd.resp_o_early", 256'(resp_o), 256'(1'b0));
            chk("rd.address_o", 256'(address_o), 256'(ea));
            chk("rd.err_o", 256'(err_o), 256'(exp_err));
            pick(sp, r);
            resp_i = r;
            burst_i = r ? beats[k] : {$urandom, $urandom};
            next();
            if (r) begin
                exp_line[64*k +: 64] = beats[k];
                k++;
            end
            chk("rd.line_partial", line_o, exp_line);
        end
        resp_i = 1'b0;
        chk("rd.resp_o", 256'(resp_o), 256'(1'b1));
        chk("rd.done_read_o", 256'(read_o), 256'(1'b0));
        chk("rd.done_address_o", 256'(address_o), 256'(ea));
        next();
        check_idle("rd.after");
    endtask

    task automatic do_write(input logic [31:0] a, input logic [255:0] line, input int sp);
        logic [31:0] ea;
        int k;
        bit r;
        ea = {a[31:5], 5'b0};
        address_i = a;
        write_i = 1'b1;
        line_i = line;
        next();
        write_i = 1'b0;
        line_i = {8{$urandom}};
        k = 0;
        while (k < 4) begin
            chk("wr.write_o", 256'(write_o), 256'(1'b1));
            chk("wr.read_o", 256'(read_o), 256'(1'b0));
            chk("wr.resp_o_early", 256'(resp_o), 256'(1'b0));
            chk("wr.address_o", 256'(address_o), 256'(ea));
            chk("wr.burst_o", 256'(burst_o), 256'(line[64*k +: 64]));
            chk("wr.line_o", line_o, exp_line);
            pick(sp, r);
            resp_i = r;
            burst_i = {$urandom, $urandom};
            next();
            if (r) k++;
        end
        resp_i = 1'b0;
        chk("wr.resp_o", 256'(resp_o), 256'(1'b1));
        chk("wr.done_write_o", 256'(write_o), 256'(1'b0));
        chk("wr.done_burst_o", 256'(burst_o), 256'(0));
        chk("wr.done_address_o", 256'(address_o), 256'(ea));
        next();
        check_idle("wr.after");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [255:0] a_line;
        #1;
        check_idle("reset");
        next();
        rst = 1'b1;
        next();
        check_idle("post_reset");

        beat_plan = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                      64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
        do_read(32'h0000_1234, 1'b0, 0);
        chk("dir.fill", line_o, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

        for (int k = 0; k < 4; k++) a_line[64*k +: 64] = {8{8'(8'hA0 + k)}};
        resp_plan = '{1, 0, 0, 1, 1, 1};
        do_write(32'h0000_8040, a_line, 0);

        do_read(32'h0001_0000, 1'b1, 0);

        resp_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next();
            exp_err = exp_err | chk_en;
            check_idle("idle_resp");
        end
        resp_i = 1'b0;

        address_i = 32'h0000_0040;
        read_i = 1'b1;
        next();
        read_i = 1'b0;
        resp_i = 1'b1;
        burst_i = 64'hDEAD_BEEF_0000_0001;
        next();
        burst_i = 64'hDEAD_BEEF_0000_0002;
        next();
        resp_i = 1'b0;
        rst = 1'b0;
        #1;
        exp_line = '0;
        exp_err = 1'b0;
        check_idle("rst_mid_read");
        next();
        chk("rst_hold.resp_o", 256'(resp_o), 256'(1'b0));
        rst = 1'b1;
        next();
        check_idle("rst_release");

        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(1) == 1) do_read($urandom, 1'b0, 30);
            else do_write($urandom, {8{$urandom}}, 30);
            for (int g = $urandom_range(2); g > 0; g--) begin
                next();
                check_idle("rand.gap");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cacheline_burst_adaptor.md
# cacheline_burst_adaptor

Bridges the cache's 256-bit line interface to the 64-bit burst physical-memory bus. It sits directly downstream of the cache datapath, consuming its line address, write-back data and read/write strobes, and returning fill lines plus a single-cycle completion pulse. Each line transfer is split into four 64-bit beats, assembled or serialised under a 2-bit beat counter and a small FSM.

## Interface
Parameters:
- s_line, 256, line width in bits
- s_burst, 64, beat width in bits; beats = s_line/s_burst = 4; s_line must be an exact multiple of s_burst

Ports:
- clk  input  1  clock; all state changes on its rising edge
- rst  input  1  reset, asynchronous, active-low (asserted when 0)
- line_i  input  256  write-back line from cache
- line_o  output  256  assembled fill line to cache
- address_i  input  32  line address from cache
- read_i  input  1  cache requests line fill
- write_i  input  1  cache requests line write-back
- resp_o  output  1  one-cycle pulse: transfer complete
- burst_i  input  64  read beat from memory
- burst_o  output  64  write beat to memory
- address_o  output  32  line-aligned memory address
- read_o  output  1  burst read request
- write_o  output  1  burst write request
- resp_i  input  1  memory accepted or returned one beat
- err_o  output  1  sticky protocol error; see Configuration

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: on a clock edge with read_i=1, latch address_i[31:5] and go to READ. With write_i=0 and read_i... precisely: read_i=1 takes priority; otherwise write_i=1 latches address_i[31:5] and line_i into the line buffer and goes to WRITE. Beat counter cleared to 0.
- address_o = {latched[31:5], 5'b0}. It is 0 in IDLE and held through DONE.
- READ: read_o=1. Each cycle with resp_i=1, line_o[64*beat +: 64] <= burst_i, beat increments. Cycles with resp_i=0 are stalls and leave state unchanged. On the resp_i that completes beat 3, go to DONE.
- WRITE: write_o=1. burst_o = buffer[64*beat +: 64], combinational from the beat counter. Each resp_i advances the beat. resp_i on beat 3 goes to DONE.
- DONE: resp_o=1 for exactly one cycle, read_o=write_o=0, then return to IDLE. Requests present during DONE are ignored. The cache must drop read_i/write_i by the edge ending DONE.
- line_o holds the last completed fill until the next read overwrites it. Partial fills are visible beat-by-beat.
- Beat counter wraps 3->0 on entry to DONE.
- resp_i in IDLE or DONE is ignored.
- burst_o is 0 outside WRITE.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, beat=0, line_o=0, line buffer=0, address_o=0, read_o=0, write_o=0, resp_o=0, burst_o=0, err_o=0.
- Reset mid-transfer aborts immediately. No resp_o is issued, and memory sees read_o/write_o drop in the same cycle.
- All outputs except burst_o are registered.
- Request sampled at edge 0 gives read_o/write_o high from cycle 1.
- Minimum latency with resp_i continuously high in cycles 1-4: resp_o in cycle 5, line_o final at cycle 5.
- Each resp_i=0 stall cycle adds one cycle of latency.

## Configuration
- CACHELINE_ADAPTOR_PROTOCOL_CHECK_EN defined: err_o is set, and stays set until reset, when any of the following occurs:
  - read_i and write_i are both high in IDLE;
  - resp_i is high in IDLE or DONE;
  - address_i changes while in READ or WRITE.
- Not defined: err_o is tied to 0 and no check logic is built. Functional behaviour is otherwise identical.

## Test plan
- Reset mid-READ after beat 1 (rst=0 at cycle 3) -> all outputs 0 immediately, state IDLE, no resp_o pulse.
- Read address_i=0x0000_1234, resp_i high cycles 1-4, burst_i=0x11..11/0x22..22/0x33..33/0x44..44 -> address_o=0x0000_1220, read_o cycles 1-4, resp_o cycle 5, line_o={0x44..44,0x33..33,0x22..22,0x11..11}.
- Write line_i=256'h…A3A2A1A0 (beat k = 0xAk repeated), resp_i pattern 1,0,0,1,1,1 -> burst_o steps A0,A1,A1,A1,A2,A3; write_o cycles 1-6; resp_o cycle 7.
- read_i=write_i=1 simultaneously -> READ taken, write_o never asserts. With CACHELINE_ADAPTOR_PROTOCOL_CHECK_EN, err_o=1 from cycle 1.
- Back-to-back: read completes (resp_o cycle 5), write_i asserted cycle 6 -> write_o from cycle 7, and line_o still holds the fill data.
- resp_i=1 in IDLE for 3 cycles -> no state change, line_o unchanged. err_o=1 only when the macro is defined.
